// File: rtl/load_store_ctrl.sv
// Load/store sequencer: decodes RV load/store instructions, aligns data to byte lanes,
// runs one memory request with a timeout, and writes back extended load data.
//
// state | meaning
// IDLE  | waiting for a load/store instruction
// CALC  | effective address, legality and alignment checks
// REQ   | memory request outstanding, wait counter running
// WB    | load result written back, done pulse
// FIN   | store complete, done pulse
// ERR   | illegal/misaligned/timeout, done plus fault pulse
module load_store_ctrl #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       insn,
  input  logic              insn_valid,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  output logic              busy,
  output logic              done,
  output logic              rd_we,
  output logic [4:0]        rd_addr,
  output logic [XLEN-1:0]   rd_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              fault_misaligned,
  output logic              fault_timeout
);

  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  if ((XLEN != 32 && XLEN != 64) || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_param
    $error("load_store_ctrl: XLEN must be 32/64 and MAX_WAIT 1..255");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    REQ  = 3'd2,
    WB   = 3'd3,
    FIN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t          state;
  logic            is_store;
  logic [2:0]      funct3_q;
  logic [11:0]     imm_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [7:0]      wait_cnt;

  logic            unused_insn;
  assign unused_insn = ^insn[19:15];

  logic [XLEN-1:0] ea;
  logic [XLEN-1:0] bit_en;
  logic [NB-1:0]   byte_en;
  logic [XLEN-1:0] wdata_n;
  logic [NB-1:0]   wstrb_n;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ld_val;
  logic            legal;
  logic            misaligned;
  logic            sbit;
  int              nbytes;
  int              shamt;

  always_comb begin
    ea         = rs1_q + {{(XLEN-12){imm_q[11]}}, imm_q};
    nbytes     = 1 << funct3_q[1:0];
    shamt      = int'(ea[LB-1:0]) * 8;
    legal      = 1'b0;
    case ({is_store, funct3_q})
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010:          legal = 1'b1;
      4'b0011, 4'b0110, 4'b1011:          legal = (XLEN == 64);
      default:                            legal = 1'b0;
    endcase
    misaligned = (ea[2:0] & 3'(nbytes - 1)) != 3'd0;
    for (int i = 0; i < NB; i++)   byte_en[i] = (i < nbytes);
    for (int i = 0; i < XLEN; i++) bit_en[i]  = (i < nbytes * 8);
    wstrb_n = byte_en << ea[LB-1:0];
    wdata_n = (rs2_q & bit_en) << shamt;
    lane    = mem_rdata >> shamt;
    sbit    = 1'b0;
    for (int i = 0; i < XLEN; i++)
      if (i == nbytes * 8 - 1) sbit = lane[i];
    // funct3[2] set means the unsigned (zero-extending) load variants
    for (int i = 0; i < XLEN; i++)
      ld_val[i] = (i < nbytes * 8) ? lane[i] : (sbit & ~funct3_q[2]);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      is_store         <= 1'b0;
      funct3_q         <= '0;
      imm_q            <= '0;
      rs1_q            <= '0;
      rs2_q            <= '0;
      wait_cnt         <= '0;
      done             <= 1'b0;
      rd_we            <= 1'b0;
      rd_addr          <= '0;
      rd_data          <= '0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      mem_wstrb        <= '0;
      fault_misaligned <= 1'b0;
      fault_timeout    <= 1'b0;
    end else begin
      done             <= 1'b0;
      rd_we            <= 1'b0;
      fault_misaligned <= 1'b0;
      fault_timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (insn_valid && (insn[6:0] == OP_LOAD || insn[6:0] == OP_STORE)) begin
            is_store <= (insn[6:0] == OP_STORE);
            funct3_q <= insn[14:12];
            imm_q    <= (insn[6:0] == OP_STORE) ? {insn[31:25], insn[11:7]} : insn[31:20];
            rs1_q    <= rs1_val;
            rs2_q    <= rs2_val;
            rd_addr  <= insn[11:7];
            state    <= CALC;
          end
        end
        CALC: begin
          if (!legal) begin
            done  <= 1'b1;
            state <= ERR;
          end else if (misaligned) begin
            done             <= 1'b1;
            fault_misaligned <= 1'b1;
            state            <= ERR;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {ea[XLEN-1:LB], {LB{1'b0}}};
            mem_wdata <= is_store ? wdata_n : '0;
            mem_wstrb <= is_store ? wstrb_n : '0;
            wait_cnt  <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          // ack wins over a timeout landing in the same cycle
          if (mem_ack || wait_cnt == 8'(MAX_WAIT - 1)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            done      <= 1'b1;
            if (!mem_ack) begin
              fault_timeout <= 1'b1;
              state         <= ERR;
            end else if (is_store) begin
              state <= FIN;
            end else begin
              rd_data <= ld_val;
              rd_we   <= (rd_addr != 5'd0);
              state   <= WB;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB, FIN, ERR: state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Self-checking bench for load_store_ctrl: directed cases plus random load/store
// traffic checked against a byte-lane reference model.
module tb_load_store_ctrl;
  localparam int XLEN = 32;
  localparam int MAXW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     insn;
  logic            insn_valid;
  logic [31:0]     rs1_val, rs2_val;
  logic            busy, done, rd_we;
  logic [4:0]      rd_addr;
  logic [31:0]     rd_data;
  logic            mem_req, mem_we;
  logic [31:0]     mem_addr, mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ack;
  logic [31:0]     mem_rdata;
  logic            fault_misaligned, fault_timeout;

  int vectors = 0;
  int miscompares = 0;

  load_store_ctrl #(.XLEN(XLEN), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .insn(insn), .insn_valid(insn_valid),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .busy(busy), .done(done),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .fault_misaligned(fault_misaligned),
    .fault_timeout(fault_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  // ack_at: REQ cycle index (0-based) in which ack is driven; >= MAXW means never
  task automatic txn(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                     input int ack_at, input logic [31:0] rdata, input bit junk);
    bit st, legal, mis, acked, e_we;
    logic [2:0] f3;
    logic [31:0] imm, ea, e_addr, e_wdata, e_rd;
    logic [3:0] e_wstrb;
    int n, off;
    longint v;
    st    = (ins[6:0] == 7'b0100011);
    f3    = ins[14:12];
    imm   = st ? {{20{ins[31]}}, ins[31:25], ins[11:7]} : {{20{ins[31]}}, ins[31:20]};
    ea    = r1 + imm;
    n     = 1 << f3[1:0];
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    off   = int'(ea[1:0]);
    mis   = legal && ((off % n) != 0);
    e_addr = ea - 32'(off);
    e_wdata = '0; e_wstrb = '0; v = 0;
    if (legal && !mis)
      for (int k = 0; k < n; k++) begin
        e_wdata[8*(off+k) +: 8] = r2[8*k +: 8];
        e_wstrb[off+k] = 1'b1;
        v += longint'(rdata[8*(off+k) +: 8]) << (8*k);
      end
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n-1))) v -= (longint'(1) << (8*n));
    e_rd = v[31:0];
    if (st) begin e_wdata = e_wdata; end
    e_we = !st && (ins[11:7] != 5'd0);

    @(negedge clk);
    insn = ins; rs1_val = r1; rs2_val = r2; insn_valid = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    if (junk) begin
      insn = enc_s(12'h010, 5'd3, 5'd4, 3'd2); mem_ack = 1'b1;
    end else insn_valid = 1'b0;
    chk("calc_busy", busy, 1);
    chk("calc_req", mem_req, 0);
    acked = 1'b0;
    if (!legal || mis) begin
      @(negedge clk);
      mem_ack = 1'b0;
      chk("err_done", done, 1);
      chk("err_mis", fault_misaligned, mis);
      chk("err_tmo", fault_timeout, 0);
      chk("err_req", mem_req, 0);
      chk("err_we", rd_we, 0);
    end else begin
      for (int c = 0; c < MAXW; c++) begin
        @(negedge clk);
        chk("req_req", mem_req, 1);
        chk("req_we", mem_we, st);
        chk("req_addr", mem_addr, e_addr);
        chk("req_wdata", mem_wdata, st ? e_wdata : 32'h0);
        chk("req_wstrb", mem_wstrb, st ? e_wstrb : 4'h0);
        mem_ack = (c == ack_at);
        mem_rdata = (c == ack_at) ? rdata : $urandom;
        if (c == ack_at) begin acked = 1'b1; break; end
      end
      @(negedge clk);
      mem_ack = junk; mem_rdata = $urandom;
      chk("fin_done", done, 1);
      chk("fin_req", mem_req, 0);
      chk("fin_tmo", fault_timeout, !acked);
      chk("fin_mis", fault_misaligned, 0);
      chk("fin_rdwe", rd_we, acked && e_we);
      chk("fin_rdaddr", rd_addr, ins[11:7]);
      if (acked && !st) chk("fin_rddata", rd_data, e_rd);
    end
    insn_valid = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    bit st;
    logic [2:0] f3;
    logic [31:0] ins;
    rst_n = 1'b0; insn = '0; insn_valid = 1'b0; rs1_val = '0; rs2_val = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_rdwe", rd_we, 0);
    chk("rst_faults", {fault_misaligned, fault_timeout}, 0);
    rst_n = 1'b1;

    txn(32'h0087A803, 32'h1000, 32'h0, 2, 32'hDEADBEEF, 1'b0);
    txn(enc_i(12'd3, 5'd1, 3'd0, 5'd5), 32'h1000, 32'h0, 0, 32'h80000000, 1'b0);
    chk("lb_val", rd_data, 32'hFFFFFF80);
    txn(enc_i(12'd3, 5'd1, 3'd4, 5'd5), 32'h1000, 32'h0, 0, 32'h80000000, 1'b0);
    chk("lbu_val", rd_data, 32'h00000080);
    txn(enc_s(12'd2, 5'd2, 5'd1, 3'd1), 32'h1000, 32'h1234ABCD, 1, 32'h0, 1'b0);
    txn(enc_i(12'd2, 5'd1, 3'd2, 5'd3), 32'h1000, 32'h0, 0, 32'h0, 1'b0);
    txn(enc_i(12'd0, 5'd1, 3'd2, 5'd3), 32'h2000, 32'h0, MAXW, 32'h0, 1'b0);
    txn(enc_i(12'd0, 5'd1, 3'd2, 5'd3), 32'h2000, 32'h0, MAXW-1, 32'h5A5A1234, 1'b1);
    txn(enc_i(12'd4, 5'd1, 3'd2, 5'd0), 32'h2000, 32'h0, 0, 32'h11223344, 1'b0);

    @(negedge clk);
    insn = 32'h00B50533; insn_valid = 1'b1;
    @(negedge clk);
    insn_valid = 1'b0;
    chk("nonmem_busy", busy, 0);
    chk("nonmem_done", done, 0);

    @(negedge clk);
    insn = 32'h0087A803; rs1_val = 32'h1000; insn_valid = 1'b1;
    @(negedge clk);
    insn_valid = 1'b0;
    @(negedge clk);
    chk("prerst_req", mem_req, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_req", mem_req, 0);
    chk("async_busy", busy, 0);
    chk("async_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(32'h0087A803, 32'h1000, 32'h0, 0, 32'hCAFEF00D, 1'b0);

    for (int t = 0; t < 60; t++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0)
        f3 = st ? 3'($urandom_range(0, 2)) : ((f3 == 3'd3 || f3 >= 3'd6) ? 3'd0 : f3);
      ins = st ? enc_s(12'($urandom), 5'($urandom), 5'($urandom), f3)
               : enc_i(12'($urandom), 5'($urandom), f3, 5'($urandom));
      txn(ins, $urandom, $urandom, $urandom_range(0, MAXW), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
